float_to_int: RTL

// - Downstream stage of the single-precision FPU adder. Consumes the adder's IEEE-754 result over the

---
 rtl/fpu_pkg.sv | 25 ++
 rtl/f2i_shift.sv | 31 +++
 rtl/float_to_int.sv | 107 ++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: IEEE-754 single field layout, bias, and the
// integer saturation constants used by float_to_int and int_to_float.
package fpu_pkg;

  localparam int FP_BIAS  = 127;
  localparam int EXP_MAX  = 255;
  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int FRAC_MSB = 22;
  localparam int EXP_W    = 10;

  localparam logic [31:0] INT_NAN     = 32'h8000_0000;
  localparam logic [31:0] INT_POS_SAT = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_NEG_SAT = 32'h8000_0000;

  typedef enum logic [2:0] {
    F2I_GET_A,
    F2I_UNPACK,
    F2I_CONVERT,
    F2I_SIGN,
    F2I_PUT_Z
  } f2i_state_t;

endpackage

// File: rtl/f2i_shift.sv
// Aligns the 24-bit significand to an integer magnitude using the unbiased
// exponent; bits shifted out on the right are dropped (truncation toward zero).
module f2i_shift
  import fpu_pkg::*;
(
  input  logic        [FRAC_MSB+1:0] m,
  input  logic signed [EXP_W-1:0]    e_unb,
  output logic        [31:0]         mag,
  output logic                       ovf
);

  logic [31:0] m_ext;

  assign m_ext = {{(31-FRAC_MSB-1){1'b0}}, m};

  always_comb begin
    mag = '0;
    ovf = 1'b0;
    if (e_unb < 10'sd0) begin
      mag = '0;
    end else if (e_unb > 10'sd30) begin
      // Magnitude of 2^31 or more cannot be represented, even -2^31 saturates.
      ovf = 1'b1;
    end else if (e_unb >= 10'sd23) begin
      mag = m_ext << (e_unb[4:0] - 5'd23);
    end else begin
      mag = m_ext >> (5'd23 - e_unb[4:0]);
    end
  end

endmodule

// File: rtl/float_to_int.sv
// IEEE-754 single to 32-bit signed integer (truncate toward zero), one
// conversion in flight, stb/ack handshakes on both sides.
module float_to_int
  import fpu_pkg::*;
#(
  parameter logic [31:0] NAN_VALUE = INT_NAN,
  parameter logic [31:0] POS_SAT   = INT_POS_SAT,
  parameter logic [31:0] NEG_SAT   = INT_NEG_SAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  f2i_state_t state, state_nxt;

  logic [31:0]             a;
  logic                    s;
  logic [FRAC_MSB+1:0]     m;
  logic signed [EXP_W-1:0] e_unb;
  logic                    is_nan, is_inf;
  logic [31:0]             mag;
  logic                    special;
  logic [31:0]             special_val;
  logic [31:0]             shift_mag;
  logic                    shift_ovf;
  logic [EXP_MSB-EXP_LSB:0] a_exp;

  assign a_exp = a[EXP_MSB:EXP_LSB];

  f2i_shift u_shift (
    .m     (m),
    .e_unb (e_unb),
    .mag   (shift_mag),
    .ovf   (shift_ovf)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      F2I_GET_A:   if (input_a_stb && input_a_ack) state_nxt = F2I_UNPACK;
      F2I_UNPACK:  state_nxt = F2I_CONVERT;
      F2I_CONVERT: state_nxt = F2I_SIGN;
      F2I_SIGN:    state_nxt = F2I_PUT_Z;
      F2I_PUT_Z:   if (output_z_stb && output_z_ack) state_nxt = F2I_GET_A;
      default:     state_nxt = F2I_GET_A;
    endcase
  end

  // Handshake outputs are registered from the next state so they are glitch
  // free and ack stays low for the whole reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= F2I_GET_A;
      input_a_ack  <= 1'b0;
      output_z_stb <= 1'b0;
      output_z     <= '0;
      a            <= '0;
      s            <= 1'b0;
      m            <= '0;
      e_unb        <= '0;
      is_nan       <= 1'b0;
      is_inf       <= 1'b0;
      mag          <= '0;
      special      <= 1'b0;
      special_val  <= '0;
    end else begin
      state        <= state_nxt;
      input_a_ack  <= (state_nxt == F2I_GET_A);
      output_z_stb <= (state_nxt == F2I_PUT_Z);
      case (state)
        F2I_GET_A: begin
          if (input_a_stb && input_a_ack) a <= input_a;
        end
        F2I_UNPACK: begin
          s      <= a[SIGN_BIT];
          m      <= {1'b1, a[FRAC_MSB:0]};
          e_unb  <= $signed({2'b00, a_exp}) - 10'sd127;
          is_nan <= (a_exp == 8'(EXP_MAX)) && (a[FRAC_MSB:0] != '0);
          is_inf <= (a_exp == 8'(EXP_MAX)) && (a[FRAC_MSB:0] == '0);
        end
        F2I_CONVERT: begin
          mag         <= shift_mag;
          special     <= 1'b0;
          special_val <= '0;
          if (is_nan) begin
            special     <= 1'b1;
            special_val <= NAN_VALUE;
          end else if (is_inf || shift_ovf) begin
            special     <= 1'b1;
            special_val <= s ? NEG_SAT : POS_SAT;
          end
        end
        F2I_SIGN: begin
          output_z <= special ? special_val : (s ? -mag : mag);
        end
        default: ;
      endcase
    end
  end

endmodule
